// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampling 8N1 UART receiver with a first-word-fall-through
// receive FIFO and sticky framing/overrun error flags.
// Optional build macro UART_RX_PARITY_EN switches the frame to 8E1 and adds
// o_parity_err (sticky, byte discarded on mismatch).
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_rx              serial line (idle high, asynchronous to i_clk)
//   i_rd_en           pop FIFO head (ignored when empty)
//   i_clr_err         clear sticky error flags
//   o_data/o_valid    FIFO head byte / FIFO not empty
//   o_level           bytes held in the FIFO
//   o_frame_err       sticky: stop bit sampled low
//   o_overrun         sticky: byte dropped because FIFO was full
//   o_parity_err      sticky: parity mismatch (UART_RX_PARITY_EN only)
//   o_busy            deframer not idle
module uart_rx_fifo #(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_rx,
  input  logic                          i_rd_en,
  input  logic                          i_clr_err,
  output logic [7:0]                    o_data,
  output logic                          o_valid,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_frame_err,
  output logic                          o_overrun,
`ifdef UART_RX_PARITY_EN
  output logic                          o_parity_err,
`endif
  output logic                          o_busy
);

  localparam int unsigned DIV_RAW = (CLK_FREQ_HZ + BAUD * 8) / (BAUD * 16);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned TW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned PW      = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t          state, state_nxt;
  logic            rx_meta, rx_s, rx_prev;
  logic [1:0]      sync_fill;
  logic [TW-1:0]   tcnt;
  logic [3:0]      s_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            par_bad;
  logic            fall_c, tick_c, samp_c;
  logic            push_c, frame_set_c, par_set_c;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [7:0]      mem [FIFO_DEPTH];
  logic            empty_c, full_c, pop_c, wr_ok_c, ovr_set_c;

  // Two-flop synchronizer. rx_prev only tracks the line once the synchronizer
  // holds real line data, so a line that is low at reset release is not
  // mistaken for a start-bit falling edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      sync_fill <= 2'b00;
      rx_prev   <= 1'b0;
    end else begin
      rx_meta   <= i_rx;
      rx_s      <= rx_meta;
      sync_fill <= {sync_fill[0], 1'b1};
      rx_prev   <= rx_s & sync_fill[1];
    end
  end

  assign fall_c = rx_prev & ~rx_s;
  assign tick_c = (tcnt == TW'(DIV - 1));
  // Start bit is sampled mid-bit (8th tick); every other bit 16 ticks later.
  assign samp_c = tick_c && (s_cnt == ((state == S_START) ? 4'd7 : 4'd15));

  // Free-running 16x tick counter, re-phased on the start edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                           tcnt <= '0;
    else if (state == S_IDLE && fall_c)  tcnt <= '0;
    else if (tick_c)                     tcnt <= '0;
    else                                 tcnt <= tcnt + TW'(1);
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (fall_c) state_nxt = S_START;
      S_START:  if (samp_c) state_nxt = rx_s ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
      S_DATA:   if (samp_c && bit_idx == 3'd7) state_nxt = S_PARITY;
      S_PARITY: if (samp_c) state_nxt = S_STOP;
`else
      S_DATA:   if (samp_c && bit_idx == 3'd7) state_nxt = S_STOP;
`endif
      S_STOP:   if (samp_c) state_nxt = rx_s ? S_IDLE : S_BREAK;
      S_BREAK:  if (rx_s) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Per-state strobes: byte push and error sets.
  always_comb begin
    push_c      = 1'b0;
    frame_set_c = 1'b0;
    par_set_c   = 1'b0;
    if (state == S_STOP && samp_c) begin
      push_c      = rx_s & ~par_bad;
      frame_set_c = ~rx_s;
    end
`ifdef UART_RX_PARITY_EN
    if (state == S_PARITY && samp_c) par_set_c = (^shift) ^ rx_s;
`endif
  end

  // Bit counters and shift register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s_cnt   <= '0;
      bit_idx <= '0;
      shift   <= '0;
      par_bad <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        s_cnt   <= '0;
        bit_idx <= '0;
      end else if (tick_c) begin
        s_cnt <= samp_c ? 4'd0 : s_cnt + 4'd1;
      end
      if (state == S_DATA && samp_c) begin
        shift[bit_idx] <= rx_s;
        bit_idx        <= bit_idx + 3'd1;
      end
      if (state == S_START)  par_bad <= 1'b0;
      else if (par_set_c)    par_bad <= 1'b1;
    end
  end

  // FIFO: pointers carry a wrap bit; a pop in the same cycle frees a slot for a push.
  assign empty_c   = (wr_ptr == rd_ptr);
  assign full_c    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_c     = i_rd_en & ~empty_c;
  assign wr_ok_c   = push_c & (~full_c | pop_c);
  assign ovr_set_c = push_c & full_c & ~pop_c;

  always_ff @(posedge i_clk) begin
    if (wr_ok_c) mem[wr_ptr[AW-1:0]] <= shift;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)   rd_ptr <= rd_ptr + PW'(1);
    end
  end

  assign o_valid = ~empty_c;
  assign o_level = wr_ptr - rd_ptr;
  assign o_data  = empty_c ? 8'h00 : mem[rd_ptr[AW-1:0]];

  // Sticky flags (set wins over clear) and busy indicator.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= 1'b0;
`endif
      o_busy       <= 1'b0;
    end else begin
      o_frame_err  <= frame_set_c | (o_frame_err & ~i_clr_err);
      o_overrun    <= ovr_set_c   | (o_overrun   & ~i_clr_err);
`ifdef UART_RX_PARITY_EN
      o_parity_err <= par_set_c   | (o_parity_err & ~i_clr_err);
`endif
      o_busy       <= (state_nxt != S_IDLE);
    end
  end

endmodule
